dat0_blk_ctrl: RTL and testbench
================================

// Module: dat0_blk_ctrl
// PURPOSE
//  Block-level sequencer for one SDIO DAT0 line datapath (bit-serial TX/RX with CRC16 engine).
//  Drives dat_phase/data_sel/oe/crc_check_en/crc_rst/state_CRC_STATUS of the line instance.
//  Frames read blocks (card->host) and write blocks (host->card): start bit, data, CRC16, end bit,
//  CRC status token, busy. Byte handshake to block buffer; status to the SDIO function core.
// PARAMETERS
//  TX_GAP      2     idle-high cycles (phase 01, oe=1) before TX start bit
//  RX_TIMEOUT  1024  max cycles waiting for RX start bit before rx_timeout
//  NCRC        2     hi-Z cycles between RX end bit and CRC status token
// PORTS
//  clk            in   1   SD clock domain
//  rst_n          in   1   asynchronous reset, active low
//  dat_width_4bit in   1   1=4-bit bus (2 cycles/byte on DAT0), 0=1-bit (8 cycles/byte)
//  blk_len        in   10  block length in bytes; 0 means 512; sampled at start
//  rd_start       in   1   pulse: transmit one block (card read)
//  wr_start       in   1   pulse: receive one block (card write)
//  abort          in   1   pulse: return to IDLE from any state
//  wr_busy        in   1   application busy after write; DAT0 held low while high
//  dat0_in        in   1   sampled DAT0 level (line rcv_data[0])
//  crc_error      in   1   sticky CRC mismatch from line
//  dat_phase      out  2   00=drive 0, 01=drive 1, 10=data, 11=CRC
//  data_sel       out  3   bit select within current byte
//  oe             out  1   line output enable
//  crc_check_en   out  1   1 during RX data/CRC
//  crc_rst        out  1   CRC16 reset
//  state_crc_status out 1  1 during CRC status token
//  tx_byte_rd     out  1   pulse: byte consumed, next byte valid on xmit_data next cycle
//  rx_byte_wr     out  1   pulse: rcv_data holds complete byte
//  busy           out  1   1 whenever state != IDLE
//  done           out  1   1-cycle pulse at block end (incl. timeout/error)
//  rx_crc_fail    out  1   latched at RX_END: CRC error or bad end bit; cleared on next start
//  rx_timeout     out  1   latched on RX_WAIT timeout; cleared on next start
// BEHAVIOUR
//  All outputs registered. Reset: state IDLE, dat_phase=01, data_sel=0, oe=0, crc_check_en=0,
//  crc_rst=1, state_crc_status=0, all pulses/flags 0.
//  Counters: bit_cnt 3b (0..7 in 1-bit; 0..1 in 4-bit using data_sel[0]), byte_cnt 10b, crc_cnt 4b.
//  data_sel=bit_cnt; last bit of byte: bit_cnt==7 (1-bit) or ==1 (4-bit); wraps to 0.
//  IDLE: phase 01, oe=0, crc_rst=1. rd_start->TX_GAP; wr_start->RX_WAIT; both same cycle: rd wins.
//  TX_GAP: phase 01, oe=1, TX_GAP cycles -> TX_START (1 cycle, phase 00, oe=1, crc_rst=0).
//  TX_DATA: phase 10, oe=1; tx_byte_rd on last bit of each byte; after blk_len bytes -> TX_CRC.
//  TX_CRC: phase 11, oe=1, exactly 16 cycles -> TX_END: phase 01, oe=1, 1 cycle -> DONE.
//  RX_WAIT: oe=0, crc_rst=1; dat0_in==0 -> RX_DATA (crc_rst=0, crc_check_en=1, phase 10);
//   RX_TIMEOUT cycles without start bit -> rx_timeout=1, DONE.
//  RX_DATA: rx_byte_wr on cycle after last bit of each byte; after blk_len bytes -> RX_CRC
//   (phase 11, 16 cycles) -> RX_END (1 cycle): rx_crc_fail = crc_error | ~dat0_in.
//  ST_GAP: oe=0, NCRC cycles. ST_TOKEN: oe=1, state_crc_status=1, 5 cycles, phases
//   00,00,01,00,01 (0-010-1) if pass; 00,01,00,01,01 (0-101-1) if fail.
//  BUSY: phase 00, oe=1, min 2 cycles, then until wr_busy==0; fail token skips BUSY -> DONE.
//  DONE: phase 01, oe=0, done=1 for 1 cycle -> IDLE.
//  abort: any state -> IDLE next cycle, oe=0, no done pulse; start pulses outside IDLE ignored.
//  blk_len==0 handled as 512 (byte_cnt terminal 511).
// TESTING
//  1-bit rd, blk_len=4, bytes A5,3C,FF,00 -> oe high 2+1+32+16+1 cycles; 4 tx_byte_rd; 1 done.
//  4-bit wr, blk_len=512 (0), good CRC, wr_busy 5 cycles -> 1024 data cycles, 512 rx_byte_wr,
//   token 0-010-1, DAT0 low 5 cycles, done, rx_crc_fail=0.
//  wr with corrupted CRC bit -> rx_crc_fail=1, token 0-101-1, no BUSY, done.
//  wr, end bit forced 0 -> rx_crc_fail=1.
//  wr_start, DAT0 held high RX_TIMEOUT cycles -> rx_timeout=1, done, IDLE.
//  abort mid TX_DATA byte 2 -> oe=0 next cycle, IDLE, no done; rd_start+wr_start same cycle -> TX.

Source files
------------

// File: rtl/dat0_blk_ctrl.sv
// Block-level sequencer for one SDIO DAT0 line: frames read (TX) and write (RX) blocks with
// start bit, data, CRC16, end bit, CRC status token and busy, and handshakes bytes to the buffer.
module dat0_blk_ctrl #(
    parameter int unsigned TX_GAP     = 2,
    parameter int unsigned RX_TIMEOUT = 1024,
    parameter int unsigned NCRC       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dat_width_4bit,
    input  logic [9:0] blk_len,
    input  logic       rd_start,
    input  logic       wr_start,
    input  logic       abort,
    input  logic       wr_busy,
    input  logic       dat0_in,
    input  logic       crc_error,
    output logic [1:0] dat_phase,
    output logic [2:0] data_sel,
    output logic       oe,
    output logic       crc_check_en,
    output logic       crc_rst,
    output logic       state_crc_status,
    output logic       tx_byte_rd,
    output logic       rx_byte_wr,
    output logic       busy,
    output logic       done,
    output logic       rx_crc_fail,
    output logic       rx_timeout
);

    localparam int unsigned WAIT_W    = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
    localparam logic [3:0]  GAP_LAST  = 4'(TX_GAP - 1);
    localparam logic [3:0]  NCRC_LAST = 4'(NCRC - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RX_TIMEOUT - 1);
    localparam logic [1:0]  PH_ZERO   = 2'b00;
    localparam logic [1:0]  PH_ONE    = 2'b01;
    localparam logic [1:0]  PH_DATA   = 2'b10;
    localparam logic [1:0]  PH_CRC    = 2'b11;
    // Token bit per token cycle, cycle 0 in bit 0: pass 0-010-1, fail 0-101-1
    localparam logic [7:0]  TOK_PASS  = 8'b0001_0100;
    localparam logic [7:0]  TOK_FAIL  = 8'b0001_1010;

    typedef enum logic [3:0] {
        S_IDLE, S_TX_GAP, S_TX_START, S_TX_DATA, S_TX_CRC, S_TX_END,
        S_RX_WAIT, S_RX_DATA, S_RX_CRC, S_RX_END, S_ST_GAP, S_ST_TOKEN,
        S_BUSY, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [9:0]        byte_cnt_q, byte_cnt_d;
    logic [3:0]        crc_cnt_q, crc_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [9:0]        blk_last_q, blk_last_d;
    logic              wide_q, wide_d;
    logic              rx_crc_fail_q, rx_crc_fail_d;
    logic              rx_timeout_q, rx_timeout_d;
    logic [1:0]        dat_phase_q, dat_phase_d;
    logic              oe_q, oe_d;
    logic              crc_check_en_q, crc_check_en_d;
    logic              crc_rst_q, crc_rst_d;
    logic              state_crc_status_q, state_crc_status_d;
    logic              tx_byte_rd_q, tx_byte_rd_d;
    logic              rx_byte_wr_q, rx_byte_wr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bit_last, byte_last, bit_last_d;
    logic [7:0]        tok_bits;

    // Next state and counters; outputs are then decoded from the next state so they are registered
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        crc_cnt_d     = crc_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        blk_last_d    = blk_last_q;
        wide_d        = wide_q;
        rx_crc_fail_d = rx_crc_fail_q;
        rx_timeout_d  = rx_timeout_q;
        rx_byte_wr_d  = 1'b0;
        bit_last      = wide_q ? (bit_cnt_q == 3'd1) : (bit_cnt_q == 3'd7);
        byte_last     = (byte_cnt_q == blk_last_q);

        if (abort) begin
            state_d    = S_IDLE;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            crc_cnt_d  = '0;
            wait_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rd_start || wr_start) begin
                        state_d       = rd_start ? S_TX_GAP : S_RX_WAIT;
                        blk_last_d    = (blk_len == 10'd0) ? 10'd511 : blk_len - 10'd1;
                        wide_d        = dat_width_4bit;
                        rx_crc_fail_d = 1'b0;
                        rx_timeout_d  = 1'b0;
                        bit_cnt_d     = '0;
                        byte_cnt_d    = '0;
                        crc_cnt_d     = '0;
                        wait_cnt_d    = '0;
                    end
                end
                S_TX_GAP: begin
                    if (crc_cnt_q == GAP_LAST) begin
                        state_d   = S_TX_START;
                        crc_cnt_d = '0;
                    end else begin
                        crc_cnt_d = crc_cnt_q + 4'd1;
                    end
                end
                S_TX_START: state_d = S_TX_DATA;
                S_TX_DATA, S_RX_DATA: begin
                    rx_byte_wr_d = (state_q == S_RX_DATA) && bit_last;
                    if (bit_last) begin
                        bit_cnt_d = '0;
                        if (byte_last) begin
                            state_d    = (state_q == S_TX_DATA) ? S_TX_CRC : S_RX_CRC;
                            byte_cnt_d = '0;
                            crc_cnt_d  = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 10'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                S_TX_CRC, S_RX_CRC: begin
                    if (crc_cnt_q == 4'd15) begin
                        state_d   = (state_q == S_TX_CRC) ? S_TX_END : S_RX_END;
                        crc_cnt_d = '0;
                    end else begin
                        crc_cnt_d = crc_cnt_q + 4'd1;
                    end
                end
                S_TX_END: state_d = S_DONE;
                S_RX_WAIT: begin
                    if (!dat0_in) begin
                        state_d    = S_RX_DATA;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_d      = S_DONE;
                        rx_timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                S_RX_END: begin
                    rx_crc_fail_d = crc_error | ~dat0_in;
                    state_d       = S_ST_GAP;
                    crc_cnt_d     = '0;
                end
                S_ST_GAP: begin
                    if (crc_cnt_q == NCRC_LAST) begin
                        state_d   = S_ST_TOKEN;
                        crc_cnt_d = '0;
                    end else begin
                        crc_cnt_d = crc_cnt_q + 4'd1;
                    end
                end
                S_ST_TOKEN: begin
                    if (crc_cnt_q == 4'd4) begin
                        state_d   = rx_crc_fail_q ? S_DONE : S_BUSY;
                        crc_cnt_d = '0;
                    end else begin
                        crc_cnt_d = crc_cnt_q + 4'd1;
                    end
                end
                // crc_cnt marks that the minimum of two busy cycles has been met
                S_BUSY: begin
                    if ((crc_cnt_q != 4'd0) && !wr_busy) begin
                        state_d   = S_DONE;
                        crc_cnt_d = '0;
                    end else begin
                        crc_cnt_d = 4'd1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        oe_d               = 1'b0;
        dat_phase_d        = PH_ONE;
        crc_check_en_d     = 1'b0;
        crc_rst_d          = 1'b0;
        state_crc_status_d = 1'b0;
        tok_bits           = rx_crc_fail_d ? TOK_FAIL : TOK_PASS;
        bit_last_d         = wide_d ? (bit_cnt_d == 3'd1) : (bit_cnt_d == 3'd7);
        case (state_d)
            S_IDLE, S_RX_WAIT, S_DONE: crc_rst_d = 1'b1;
            S_TX_GAP: begin
                oe_d      = 1'b1;
                crc_rst_d = 1'b1;
            end
            S_TX_START: begin
                oe_d        = 1'b1;
                dat_phase_d = PH_ZERO;
            end
            S_TX_DATA: begin
                oe_d        = 1'b1;
                dat_phase_d = PH_DATA;
            end
            S_TX_CRC: begin
                oe_d        = 1'b1;
                dat_phase_d = PH_CRC;
            end
            S_TX_END: oe_d = 1'b1;
            S_RX_DATA: begin
                dat_phase_d    = PH_DATA;
                crc_check_en_d = 1'b1;
            end
            S_RX_CRC: begin
                dat_phase_d    = PH_CRC;
                crc_check_en_d = 1'b1;
            end
            S_ST_TOKEN: begin
                oe_d               = 1'b1;
                state_crc_status_d = 1'b1;
                dat_phase_d        = {1'b0, tok_bits[crc_cnt_d[2:0]]};
            end
            S_BUSY: begin
                oe_d        = 1'b1;
                dat_phase_d = PH_ZERO;
            end
            default: ;
        endcase
        tx_byte_rd_d = (state_d == S_TX_DATA) && bit_last_d;
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= S_IDLE;
            bit_cnt_q          <= '0;
            byte_cnt_q         <= '0;
            crc_cnt_q          <= '0;
            wait_cnt_q         <= '0;
            blk_last_q         <= '0;
            wide_q             <= 1'b0;
            rx_crc_fail_q      <= 1'b0;
            rx_timeout_q       <= 1'b0;
            dat_phase_q        <= PH_ONE;
            oe_q               <= 1'b0;
            crc_check_en_q     <= 1'b0;
            crc_rst_q          <= 1'b1;
            state_crc_status_q <= 1'b0;
            tx_byte_rd_q       <= 1'b0;
            rx_byte_wr_q       <= 1'b0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            bit_cnt_q          <= bit_cnt_d;
            byte_cnt_q         <= byte_cnt_d;
            crc_cnt_q          <= crc_cnt_d;
            wait_cnt_q         <= wait_cnt_d;
            blk_last_q         <= blk_last_d;
            wide_q             <= wide_d;
            rx_crc_fail_q      <= rx_crc_fail_d;
            rx_timeout_q       <= rx_timeout_d;
            dat_phase_q        <= dat_phase_d;
            oe_q               <= oe_d;
            crc_check_en_q     <= crc_check_en_d;
            crc_rst_q          <= crc_rst_d;
            state_crc_status_q <= state_crc_status_d;
            tx_byte_rd_q       <= tx_byte_rd_d;
            rx_byte_wr_q       <= rx_byte_wr_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
        end
    end

    assign dat_phase        = dat_phase_q;
    assign data_sel         = bit_cnt_q;
    assign oe               = oe_q;
    assign crc_check_en     = crc_check_en_q;
    assign crc_rst          = crc_rst_q;
    assign state_crc_status = state_crc_status_q;
    assign tx_byte_rd       = tx_byte_rd_q;
    assign rx_byte_wr       = rx_byte_wr_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign rx_crc_fail      = rx_crc_fail_q;
    assign rx_timeout       = rx_timeout_q;

endmodule

// File: tb/tb_dat0_blk_ctrl.sv
// Bench for dat0_blk_ctrl: a table of block transfers plus random transfers, each checked
// against per-block totals derived from the framing rules, and an abort sequence.
module tb_dat0_blk_ctrl;

    localparam int TX_GAP     = 2;
    localparam int NCRC       = 2;
    localparam int RX_TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dat_width_4bit, rd_start, wr_start, abort, wr_busy, dat0_in, crc_error;
    logic [9:0] blk_len;
    logic [1:0] dat_phase;
    logic [2:0] data_sel;
    logic       oe, crc_check_en, crc_rst, state_crc_status, tx_byte_rd, rx_byte_wr;
    logic       busy, done, rx_crc_fail, rx_timeout;

    dat0_blk_ctrl #(.TX_GAP(TX_GAP), .RX_TIMEOUT(RX_TIMEOUT), .NCRC(NCRC)) dut (
        .clk(clk), .rst_n(rst_n), .dat_width_4bit(dat_width_4bit), .blk_len(blk_len),
        .rd_start(rd_start), .wr_start(wr_start), .abort(abort), .wr_busy(wr_busy),
        .dat0_in(dat0_in), .crc_error(crc_error), .dat_phase(dat_phase), .data_sel(data_sel),
        .oe(oe), .crc_check_en(crc_check_en), .crc_rst(crc_rst),
        .state_crc_status(state_crc_status), .tx_byte_rd(tx_byte_rd), .rx_byte_wr(rx_byte_wr),
        .busy(busy), .done(done), .rx_crc_fail(rx_crc_fail), .rx_timeout(rx_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rd; bit wr; bit wide; int blen; bit bad_crc; bit bad_end; bit tmo; bit noise;
        int hold; int dly;
        int e_oe; int e_data; int e_bytes; int e_busy; int e_bsy; int e_scs;
        bit [4:0] e_tok; bit e_fail; bit e_tmo;
    } vec_t;

    int n_run = 0;
    int n_fail = 0;
    bit cur_wide = 1'b0;

    // Cumulative line activity, sampled mid-cycle
    int m_oe = 0, m_p10 = 0, m_tx = 0, m_tx_good = 0, m_rx = 0, m_rx_good = 0;
    int m_done = 0, m_busy = 0, m_bsy = 0, m_scs = 0, m_cce = 0, m_dsel = 0, m_tokbad = 0;
    bit [4:0] tok_sh = '0;
    bit prev_p10 = 1'b0, prev_last = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (oe) m_oe <= m_oe + 1;
            if (dat_phase == 2'b10) begin
                m_p10  <= m_p10 + 1;
                m_dsel <= m_dsel + int'(data_sel);
            end
            if (tx_byte_rd) m_tx <= m_tx + 1;
            if (tx_byte_rd && dat_phase == 2'b10 && data_sel == (cur_wide ? 3'd1 : 3'd7))
                m_tx_good <= m_tx_good + 1;
            if (rx_byte_wr) m_rx <= m_rx + 1;
            if (rx_byte_wr && prev_p10 && prev_last) m_rx_good <= m_rx_good + 1;
            if (done) m_done <= m_done + 1;
            if (busy) m_busy <= m_busy + 1;
            if (oe && dat_phase == 2'b00 && !state_crc_status) m_bsy <= m_bsy + 1;
            if (crc_check_en) m_cce <= m_cce + 1;
            if (state_crc_status) begin
                m_scs  <= m_scs + 1;
                tok_sh <= {tok_sh[3:0], dat_phase[0]};
                if (dat_phase[1]) m_tokbad <= m_tokbad + 1;
            end
            prev_p10  <= (dat_phase == 2'b10);
            prev_last <= (data_sel == (cur_wide ? 3'd1 : 3'd7));
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Block totals from the framing rules: gap, start, data, CRC, end, token, busy, done
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int nb = (v.blen == 0) ? 512 : v.blen;
        int data = nb * (v.wide ? 2 : 8);
        int bl;
        r.e_tok = 5'b0; r.e_fail = 1'b0; r.e_tmo = 1'b0;
        if (v.rd) begin
            r.e_bytes = nb; r.e_data = data; r.e_oe = TX_GAP + 1 + data + 16 + 1;
            r.e_busy = r.e_oe + 1; r.e_bsy = 1; r.e_scs = 0;
        end else if (v.tmo) begin
            r.e_bytes = 0; r.e_data = 0; r.e_oe = 0; r.e_busy = RX_TIMEOUT + 1;
            r.e_bsy = 0; r.e_scs = 0; r.e_tmo = 1'b1;
        end else begin
            r.e_fail = v.bad_crc | v.bad_end;
            bl = r.e_fail ? 0 : ((v.hold + 1 > 2) ? v.hold + 1 : 2);
            r.e_bytes = nb; r.e_data = data; r.e_oe = 5 + bl; r.e_bsy = bl; r.e_scs = 5;
            r.e_busy = (v.dly + 1) + data + 16 + 1 + NCRC + 5 + bl + 1;
            r.e_tok = r.e_fail ? 5'b01011 : 5'b00101;
        end
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input int k);
        int b_oe = m_oe, b_p10 = m_p10, b_tx = m_tx, b_txg = m_tx_good, b_rx = m_rx;
        int b_rxg = m_rx_good, b_done = m_done, b_busy = m_busy, b_bsy = m_bsy;
        int b_scs = m_scs, b_cce = m_cce, b_dsel = m_dsel, b_tokbad = m_tokbad;
        int cyc = 0;
        bit seen = 1'b0;
        string p = $sformatf("v%0d", k);
        cur_wide = v.wide;
        dat_width_4bit = v.wide;
        blk_len = 10'(v.blen);
        crc_error = v.bad_crc;
        @(posedge clk); #1;
        rd_start = v.rd; wr_start = v.wr;
        wr_busy = v.wr && !v.rd && (v.hold > 0);
        @(posedge clk); #1;
        rd_start = 1'b0; wr_start = 1'b0;
        if (v.wr && !v.rd && !v.tmo) begin
            repeat (v.dly) begin @(posedge clk); #1; end
            dat0_in = 1'b0;
            for (int i = 0; i < v.e_data + 16; i++) begin
                @(posedge clk); #1;
                dat0_in = 1'($urandom);
            end
            @(posedge clk); #1;
            dat0_in = !v.bad_end;
            @(posedge clk); #1;
            dat0_in = 1'b1;
        end
        while (cyc < 6000) begin
            if (m_done > b_done) begin
                seen = 1'b1;
                break;
            end
            if (wr_busy && (m_bsy - b_bsy) >= v.hold) wr_busy = 1'b0;
            cyc++;
            rd_start = v.noise && (cyc == 5);
            wr_start = v.noise && (cyc == 5);
            @(posedge clk); #1;
        end
        rd_start = 1'b0; wr_start = 1'b0;
        chk({p, "_done_seen"}, int'(seen), 1);
        @(negedge clk);
        chk({p, "_idle_after"}, int'(busy), 0);
        chk({p, "_crc_fail"}, int'(rx_crc_fail), int'(v.e_fail));
        chk({p, "_timeout"}, int'(rx_timeout), int'(v.e_tmo));
        chk({p, "_oe_cycles"}, m_oe - b_oe, v.e_oe);
        chk({p, "_data_cycles"}, m_p10 - b_p10, v.e_data);
        chk({p, "_tx_byte_rd"}, m_tx - b_tx, v.rd ? v.e_bytes : 0);
        chk({p, "_tx_rd_align"}, m_tx_good - b_txg, v.rd ? v.e_bytes : 0);
        chk({p, "_rx_byte_wr"}, m_rx - b_rx, v.rd ? 0 : v.e_bytes);
        chk({p, "_rx_wr_align"}, m_rx_good - b_rxg, v.rd ? 0 : v.e_bytes);
        chk({p, "_done_cnt"}, m_done - b_done, 1);
        chk({p, "_busy_cycles"}, m_busy - b_busy, v.e_busy);
        chk({p, "_low_cycles"}, m_bsy - b_bsy, v.e_bsy);
        chk({p, "_token_cycles"}, m_scs - b_scs, v.e_scs);
        chk({p, "_crc_chk_cycles"}, m_cce - b_cce, (v.rd || v.tmo) ? 0 : v.e_data + 16);
        chk({p, "_data_sel_sum"}, m_dsel - b_dsel, v.e_bytes * (v.wide ? 1 : 28));
        if (v.e_scs == 5) begin
            chk({p, "_token"}, int'(tok_sh), int'(v.e_tok));
            chk({p, "_token_phase"}, m_tokbad - b_tokbad, 0);
        end
        wr_busy = 1'b0;
        crc_error = 1'b0;
    endtask

    initial begin
        vec_t tbl[7];
        vec_t v;
        int b_done, b_tx, cyc;
        rst_n = 1'b0; dat_width_4bit = 1'b0; blk_len = '0; rd_start = 1'b0; wr_start = 1'b0;
        abort = 1'b0; wr_busy = 1'b0; dat0_in = 1'b1; crc_error = 1'b0;

        //          rd wr wd blen bc be to nz hold dly  oe  data bytes busy bsy scs tok      fail tmo
        tbl[0] = '{1, 0, 0, 4,   0, 0, 0, 0, 0, 0,  52,  32,   4,   53, 1, 0, 5'b00000, 0, 0};
        tbl[1] = '{1, 1, 1, 3,   0, 0, 0, 1, 0, 0,  26,   6,   3,   27, 1, 0, 5'b00000, 0, 0};
        tbl[2] = '{0, 1, 1, 0,   0, 0, 0, 0, 4, 3,  10, 1024, 512, 1058, 5, 5, 5'b00101, 0, 0};
        tbl[3] = '{0, 1, 0, 2,   1, 0, 0, 0, 3, 0,   5,  16,   2,   42, 0, 5, 5'b01011, 1, 0};
        tbl[4] = '{0, 1, 1, 1,   0, 1, 0, 0, 0, 7,   5,   2,   1,   35, 0, 5, 5'b01011, 1, 0};
        tbl[5] = '{0, 1, 0, 1,   0, 0, 0, 1, 0, 1,   7,   8,   1,   37, 2, 5, 5'b00101, 0, 0};
        tbl[6] = '{0, 1, 0, 4,   0, 0, 1, 0, 0, 0,   0,   0,   0, 1025, 0, 0, 5'b00000, 0, 1};

        repeat (2) @(negedge clk);
        chk("rst_dat_phase", int'(dat_phase), 1);
        chk("rst_data_sel", int'(data_sel), 0);
        chk("rst_oe", int'(oe), 0);
        chk("rst_crc_check_en", int'(crc_check_en), 0);
        chk("rst_crc_rst", int'(crc_rst), 1);
        chk("rst_state_crc_status", int'(state_crc_status), 0);
        chk("rst_pulses", int'({tx_byte_rd, rx_byte_wr, done}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_flags", int'({rx_crc_fail, rx_timeout}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

        // Abort in the middle of the second byte of a read
        b_done = m_done; b_tx = m_tx; cyc = 0;
        cur_wide = 1'b0; dat_width_4bit = 1'b0; blk_len = 10'd4;
        @(posedge clk); #1; rd_start = 1'b1;
        @(posedge clk); #1; rd_start = 1'b0;
        while ((m_tx - b_tx) < 1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_reach_byte2", int'((m_tx - b_tx) >= 1), 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("abort_pre_oe", int'(oe), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_oe", int'(oe), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_phase", int'(dat_phase), 1);
        chk("abort_data_sel", int'(data_sel), 0);
        repeat (60) @(negedge clk);
        chk("abort_no_done", m_done - b_done, 0);

        for (int i = 0; i < 25; i++) begin
            v = '{default: 0};
            v.rd      = 1'($urandom_range(0, 1));
            v.wr      = !v.rd || ($urandom_range(0, 3) == 0);
            v.wide    = 1'($urandom_range(0, 1));
            v.blen    = $urandom_range(1, 40);
            v.bad_crc = !v.rd && ($urandom_range(0, 3) == 0);
            v.bad_end = !v.rd && ($urandom_range(0, 3) == 0);
            v.noise   = 1'($urandom_range(0, 1));
            v.hold    = $urandom_range(0, 6);
            v.dly     = $urandom_range(0, 30);
            run_vec(model(v), 100 + i);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
